paddle_ctrl: RTL

Parametrised paddle position controller, next generation of the pong paddle. Supports AI tracking and manual up/down control. Adds a per-frame speed ramp, a deadband, overshoot-free stepping and re-centring while the ball moves away. Drives the upper-left X/Y of one paddle into the renderer and collision logic; one instance per side.

---
 rtl/pong_pkg.sv | 17 +
 rtl/paddle_speed_ramp.sv | 49 ++++
 rtl/paddle_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants and the paddle controller state type.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int WALL_W   = 8;

  localparam int SIDE_LEFT  = 1;
  localparam int SIDE_RIGHT = 0;

  typedef enum logic [1:0] {
    RECENTER = 2'd0,
    TRACK    = 2'd1,
    MANUAL   = 2'd2
  } paddle_state_t;

endpackage

// File: rtl/paddle_speed_ramp.sv
// Per-frame speed ramp: accelerates while motion continues in one direction,
// drops back to the minimum on a stop, a reversal or a forced restart.
// The speed output is the step size to use on the current update.
module paddle_speed_ramp #(
  parameter int SPD_W     = 8,
  parameter int MIN_SPEED = 1,
  parameter int MAX_SPEED = 8,
  parameter int ACCEL     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             step_valid,
  input  logic             dir,
  input  logic             force_min,
  output logic [SPD_W-1:0] speed
);

  localparam logic [SPD_W-1:0] MIN_S = SPD_W'(MIN_SPEED);
  localparam logic [SPD_W:0]   MAX_W = (SPD_W+1)'(MAX_SPEED);
  localparam logic [SPD_W:0]   ACC_W = (SPD_W+1)'(ACCEL);

  logic [SPD_W-1:0] speed_q;
  logic             last_dir;
  logic [SPD_W:0]   sum;

  // Restart or reversal steps at minimum speed; otherwise keep the ramped value.
  always_comb begin
    speed = speed_q;
    if (force_min || (dir != last_dir)) speed = MIN_S;
    sum = {1'b0, speed} + ACC_W;
  end

  // After a real move, ramp from the speed just used; any idle update resets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q  <= MIN_S;
      last_dir <= 1'b0;
    end else if (en) begin
      if (step_valid) begin
        speed_q  <= (sum > MAX_W) ? MAX_W[SPD_W-1:0] : sum[SPD_W-1:0];
        last_dir <= dir;
      end else begin
        speed_q <= MIN_S;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: AI tracking of an approaching ball, re-centring
// while the ball moves away, and manual button control. Position changes only
// on unfrozen frame ticks, with deadband, overshoot-free steps and wall clamps.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = pong_pkg::SCREEN_W,
  parameter int SCREEN_H   = pong_pkg::SCREEN_H,
  parameter int WALL_W     = pong_pkg::WALL_W,
  parameter int PADDLE_W   = 16,
  parameter int PADDLE_LEN = 64,
  parameter int SIDE       = 1,
  parameter int MIN_SPEED  = 1,
  parameter int MAX_SPEED  = 8,
  parameter int ACCEL      = 1,
  parameter int DEADBAND   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       manual,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [9:0] ball_y,
  input  logic       ball_dir,
  output logic [9:0] outX,
  output logic [8:0] outY,
  output logic       moving,
  output logic       dir_up,
  output logic       at_limit
);

  localparam int SPD_W = 8;
  localparam logic [8:0]         Y_RST   = 9'((SCREEN_H - PADDLE_LEN) / 2);
  localparam logic signed [11:0] Y_MIN   = 12'(WALL_W);
  localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - WALL_W - PADDLE_LEN);
  localparam logic [10:0]        HALF_L  = 11'(PADDLE_LEN / 2);
  localparam logic [9:0]         MID_Y   = 10'(SCREEN_H / 2);
  localparam logic [10:0]        DB      = 11'(DEADBAND);
  localparam logic               SIDE_B  = 1'(SIDE);

  paddle_state_t     state, nxt_state;
  logic              tick;
  logic              force_min;
  logic [9:0]        target;
  logic [10:0]       centre;
  logic signed [10:0] err;
  logic [10:0]       abs_err;
  logic              req, req_dir, moved;
  logic [10:0]       step;
  logic signed [11:0] cand, clamped;
  logic [8:0]        y_new;
  logic [SPD_W-1:0]  speed;

  assign tick = frame_tick & ~freeze;
  assign outX = (SIDE == SIDE_LEFT) ? 10'd0 : 10'(SCREEN_W - PADDLE_W);

  // Mode selection for this tick; a mode change restarts the speed ramp.
  always_comb begin
    nxt_state = RECENTER;
    if (manual)                nxt_state = MANUAL;
    else if (ball_dir == SIDE_B) nxt_state = TRACK;
    force_min = (nxt_state != state);
  end

  // Move request, signed error, non-overshooting step and wall clamp.
  always_comb begin
    target  = (nxt_state == TRACK) ? ball_y : MID_Y;
    centre  = {2'b00, outY} + HALF_L;
    err     = $signed({1'b0, target}) - $signed(centre);
    abs_err = err[10] ? 11'(-err) : 11'(err);
    if (nxt_state == MANUAL) begin
      req     = btn_up ^ btn_down;
      req_dir = btn_up;
      step    = 11'(speed);
    end else begin
      req     = (abs_err > DB);
      req_dir = err[10];
      step    = (11'(speed) < abs_err) ? 11'(speed) : abs_err;
    end
    cand = req_dir ? $signed({3'b000, outY}) - $signed({1'b0, step})
                   : $signed({3'b000, outY}) + $signed({1'b0, step});
    clamped = cand;
    if (cand < Y_MIN) clamped = Y_MIN;
    if (cand > Y_MAX) clamped = Y_MAX;
    y_new = req ? clamped[8:0] : outY;
    moved = (y_new != outY);
  end

  // A step that the clamp swallows entirely counts as a stop for the ramp.
  paddle_speed_ramp #(
    .SPD_W    (SPD_W),
    .MIN_SPEED(MIN_SPEED),
    .MAX_SPEED(MAX_SPEED),
    .ACCEL    (ACCEL)
  ) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .en        (tick),
    .step_valid(moved),
    .dir       (req_dir),
    .force_min (force_min),
    .speed     (speed)
  );

  // State and position registers update only on an unfrozen frame tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RECENTER;
      outY     <= Y_RST;
      moving   <= 1'b0;
      dir_up   <= 1'b0;
      at_limit <= 1'b0;
    end else if (tick) begin
      state    <= nxt_state;
      outY     <= y_new;
      moving   <= moved;
      if (moved) dir_up <= req_dir;
      at_limit <= ($signed({3'b000, y_new}) == Y_MIN) ||
                  ($signed({3'b000, y_new}) == Y_MAX);
    end
  end

endmodule
